// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit period and receiver states.
// The transmitter imports this package as well.
`timescale 1ns/1ps
package uart_pkg;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// The reset value is a parameter so idle-high lines do not glitch out of reset.
`timescale 1ns/1ps
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: centre-of-bit sampling of a synchronized line.
// Good frames strobe data_valid; a low stop bit strobes frame_error instead.
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      data_valid,
  output logic                      rx_busy,
  output logic                      frame_error
);

  localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] data_out_q, data_out_d;
  logic                      data_valid_q, data_valid_d;
  logic                      frame_error_q, frame_error_d;

  sync_2ff #(
    .RESET_VAL(1'b1)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q + 1'b1;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      // Re-check the line half a bit in so short low glitches are dropped.
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          if (bit_idx_q == LAST_BIT) state_d = STOP;
          else                       bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      // Leaving mid stop bit lets an immediately following start edge be seen.
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d = '0;
          if (rx_s) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign frame_error = frame_error_q;
  assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: a table of frames
// plus hand sequences for glitch, back-to-back and mid-frame reset cases.
`timescale 1ns/1ps
module tb_uart_rx;

  typedef struct {
    logic [7:0] data;
    int         per_x100;
    bit         stop_bit;
    bit         check_timing;
    logic [7:0] exp_data;
    int         exp_valid;
    int         exp_ferr;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rx_busy;
  logic       frame_error;

  int checks_total;
  int checks_passed;
  int cycle;
  int frame_start;

  int valid_cnt;
  int ferr_cnt;
  int overlap_cnt;
  int busy_run;
  int last_busy_run;
  int valid_cyc[$];
  int valid_dat[$];

  vec_t vecs[7];
  vec_t final_vec;

  uart_rx #(
    .CLKS_PER_BIT(16)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .rx_busy    (rx_busy),
    .frame_error(frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    valid_cnt     = 0;
    ferr_cnt      = 0;
    overlap_cnt   = 0;
    busy_run      = 0;
    last_busy_run = 0;
  end

  // Outputs are observed on the falling edge, away from the updating edge.
  always @(negedge clk) begin
    if (data_valid) begin
      valid_cnt <= valid_cnt + 1;
      valid_cyc.push_back(cycle);
      valid_dat.push_back(int'(data_out));
    end
    if (frame_error) ferr_cnt <= ferr_cnt + 1;
    if (data_valid && frame_error) overlap_cnt <= overlap_cnt + 1;
    if (rx_busy) begin
      busy_run <= busy_run + 1;
    end else if (busy_run != 0) begin
      last_busy_run <= busy_run;
      busy_run      <= 0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int qdat(input int i);
    return (i < valid_dat.size()) ? valid_dat[i] : -1;
  endfunction

  function automatic int qcyc(input int i);
    return (i < valid_cyc.size()) ? valid_cyc[i] : -1;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string name, input int got, input int exp);
    checks_total++;
    if (got == exp) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  task automatic checkRange(input string name, input int got, input int lo, input int hi);
    checks_total++;
    if (got >= lo && got <= hi) checks_passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, got, lo, hi);
  endtask

  // Drives one frame; bit b ends at floor(per_x100*(b+1)/100) cycles so
  // fractional baud skew can be expressed. A low stop bit is held 40 more cycles.
  task automatic applyStimulus(input logic [7:0] data, input int per_x100, input bit stop_bit);
    int t;
    int tgt;
    t = 0;
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      rx = 1'b0;
      else if (b == 9) rx = stop_bit;
      else             rx = data[b-1];
      tgt = (per_x100 * (b + 1)) / 100;
      while (t < tgt) begin
        step(1);
        t++;
      end
    end
    if (!stop_bit) begin
      step(40);
      rx = 1'b1;
    end
  endtask

  task automatic runVector(input vec_t v, input int idx);
    int vc0;
    int fc0;
    vc0 = valid_cnt;
    fc0 = ferr_cnt;
    frame_start = cycle;
    applyStimulus(v.data, v.per_x100, v.stop_bit);
    step(48);
    checkOutput($sformatf("v%0d_valid_count", idx), valid_cnt - vc0, v.exp_valid);
    checkOutput($sformatf("v%0d_ferr_count", idx), ferr_cnt - fc0, v.exp_ferr);
    checkOutput($sformatf("v%0d_data_out", idx), int'(data_out), int'(v.exp_data));
    if (v.check_timing) begin
      checkRange($sformatf("v%0d_latency", idx), qcyc(valid_cyc.size() - 1) - frame_start, 154, 156);
      checkRange($sformatf("v%0d_busy_cycles", idx), last_busy_run, 150, 154);
    end
  endtask

  initial begin
    int vc0;
    int fc0;
    int w;

    checks_total  = 0;
    checks_passed = 0;

    vecs[0] = '{8'hA5, 1600, 1'b1, 1'b1, 8'hA5, 1, 0};
    vecs[1] = '{8'h3C, 1600, 1'b1, 1'b1, 8'h3C, 1, 0};
    vecs[2] = '{8'h81, 1600, 1'b0, 1'b0, 8'h3C, 0, 1};
    vecs[3] = '{8'h7E, 1600, 1'b1, 1'b1, 8'h7E, 1, 0};
    vecs[4] = '{8'hC3, 1664, 1'b1, 1'b0, 8'hC3, 1, 0};
    vecs[5] = '{8'hC3, 1536, 1'b1, 1'b0, 8'hC3, 1, 0};
    vecs[6] = '{8'hC3, 1700, 1'b1, 1'b0, 8'hC3, 1, 0};
    final_vec = '{8'h55, 1600, 1'b1, 1'b1, 8'h55, 1, 0};

    rx    = 1'b1;
    reset = 1'b1;
    step(4);
    reset = 1'b0;
    step(2);
    checkOutput("reset_data_out", int'(data_out), 0);
    checkOutput("reset_data_valid", int'(data_valid), 0);
    checkOutput("reset_frame_error", int'(frame_error), 0);
    checkOutput("reset_rx_busy", int'(rx_busy), 0);

    for (int i = 0; i < 7; i++) runVector(vecs[i], i);

    $display("[TB] glitch rejection");
    vc0 = valid_cnt;
    fc0 = ferr_cnt;
    rx = 1'b0;
    step(5);
    rx = 1'b1;
    w = 0;
    while (rx_busy && w < 40) begin
      step(1);
      w++;
    end
    checkRange("glitch_busy_drop", w, 0, 8);
    step(40);
    checkOutput("glitch_valid_count", valid_cnt - vc0, 0);
    checkOutput("glitch_ferr_count", ferr_cnt - fc0, 0);

    $display("[TB] back-to-back frames");
    vc0 = valid_cnt;
    frame_start = cycle;
    applyStimulus(8'h00, 1600, 1'b1);
    applyStimulus(8'hFF, 1600, 1'b1);
    step(48);
    checkOutput("b2b_valid_count", valid_cnt - vc0, 2);
    checkOutput("b2b_first_byte", qdat(vc0), 8'h00);
    checkOutput("b2b_second_byte", qdat(vc0 + 1), 8'hFF);
    checkRange("b2b_first_latency", qcyc(vc0) - frame_start, 154, 156);
    checkOutput("b2b_spacing", qcyc(vc0 + 1) - qcyc(vc0), 160);

    $display("[TB] reset during bit 4");
    vc0 = valid_cnt;
    fork
      applyStimulus(8'hFF, 1600, 1'b1);
      begin
        step(88);
        reset = 1'b1;
        step(1);
        checkOutput("midreset_rx_busy", int'(rx_busy), 0);
        checkOutput("midreset_data_out", int'(data_out), 0);
        reset = 1'b0;
      end
    join
    step(48);
    checkOutput("midreset_valid_count", valid_cnt - vc0, 0);

    runVector(final_vec, 7);

    checkOutput("valid_ferr_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
